sha256_state_acc: RTL and testbench

Parametrised chaining-state accumulator for the hash pipeline. It holds all WORDS chaining words of a multi-block message and adds each compression result into them, modulo 2^WIDTH. It tracks the block index up to a programmable block count and presents the final digest with a valid pulse. It sits between the message scheduler/compression core and the nonce/target comparator, and feeds `chain_out` back to the compression core as its initial a..h.

---
 rtl/sha256_state_acc.sv | 166 ++++++++++++++++
 tb/tb_sha256_state_acc.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_state_acc.sv
// sha256_state_acc: chaining-state accumulator for multi-block SHA-256.
// Adds each compression result into the chaining words (mod 2^WIDTH per word).
// It counts blocks up to a latched block count and emits the final digest.
// Optional feature macro: SHA_MIDSTATE_EN (adds start_mid and a midstate register).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, num_blocks : begin a message from IV; block count (0 treated as 1)
//   start_mid         : resume from the saved midstate (only with SHA_MIDSTATE_EN)
//   comp_valid/ready  : compression result handshake
//   comp_in           : compression output, word0 (a) at LSBs
//   chain_out         : current chaining value
//   digest            : final sum
//   digest_valid      : one-cycle pulse when digest updates
//   busy, blk_idx     : accumulating; index of the block currently expected
module sha256_state_acc #(
   parameter int WIDTH = 32,
   parameter int WORDS = 8,
   parameter int BLK_W = 4,
   parameter logic [WORDS*WIDTH-1:0] IV = {
      32'h5be0cd19, 32'h1f83d9ab,
      32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372,
      32'hbb67ae85, 32'h6a09e667
   }
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
`ifdef SHA_MIDSTATE_EN
   input  logic                   start_mid,
`endif
   input  logic [BLK_W-1:0]       num_blocks,
   input  logic                   comp_valid,
   output logic                   comp_ready,
   input  logic [WORDS*WIDTH-1:0] comp_in,
   output logic [WORDS*WIDTH-1:0] chain_out,
   output logic [WORDS*WIDTH-1:0] digest,
   output logic                   digest_valid,
   output logic                   busy,
   output logic [BLK_W-1:0]       blk_idx
);

   typedef enum logic {
      IDLE,
      ACCUM
   } state_t;

   localparam int N = WORDS * WIDTH;

   state_t           state_q, state_d;
   logic [N-1:0]     chain_q, chain_d;
   logic [N-1:0]     digest_q, digest_d;
   logic             dv_q, dv_d;
   logic [BLK_W-1:0] blk_q, blk_d;
   logic [BLK_W-1:0] nb_q, nb_d;

   logic [N-1:0]     sum;
   logic [BLK_W-1:0] nb_eff;
   logic             xfer;
   logic             last;

`ifdef SHA_MIDSTATE_EN
   logic [N-1:0]     mid_q, mid_d;
   logic             mid_v_q, mid_v_d;
`endif

   assign comp_ready   = (state_q == ACCUM);
   assign busy         = (state_q == ACCUM);
   assign chain_out    = chain_q;
   assign digest       = digest_q;
   assign digest_valid = dv_q;
   assign blk_idx      = blk_q;

   assign xfer   = comp_valid && comp_ready;
   assign nb_eff = (num_blocks == '0) ? BLK_W'(1) : num_blocks;
   // nb_q is never 0, so nb_q-1 cannot underflow.  ">=" keeps a
   // midstate resume with nb=1 (blk_idx=1) from running forever.
   assign last   = (blk_q >= nb_q - BLK_W'(1));

   // Word-wise add; carries never cross word boundaries.
   always_comb begin
      sum = '0;
      for (int i = 0; i < WORDS; i++) begin
         sum[i*WIDTH +: WIDTH] =
            chain_q[i*WIDTH +: WIDTH] + comp_in[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      state_d  = state_q;
      chain_d  = chain_q;
      digest_d = digest_q;
      dv_d     = 1'b0;
      blk_d    = blk_q;
      nb_d     = nb_q;
`ifdef SHA_MIDSTATE_EN
      mid_d    = mid_q;
      mid_v_d  = mid_v_q;
`endif
      if (start) begin
         chain_d = IV;
         blk_d   = '0;
         nb_d    = nb_eff;
         state_d = ACCUM;
      end
`ifdef SHA_MIDSTATE_EN
      else if (start_mid) begin
         nb_d    = nb_eff;
         state_d = ACCUM;
         if (mid_v_q) begin
            chain_d = mid_q;
            blk_d   = BLK_W'(1);
         end else begin
            chain_d = IV;
            blk_d   = '0;
         end
      end
`endif
      else if (xfer) begin
         if (last) begin
            digest_d = sum;
            dv_d     = 1'b1;
            chain_d  = IV;
            blk_d    = '0;
            state_d  = IDLE;
         end else begin
            chain_d = sum;
            blk_d   = blk_q + BLK_W'(1);
`ifdef SHA_MIDSTATE_EN
            // Block 0 of a multi-block message: save for later nonces.
            if (blk_q == '0) begin
               mid_d   = sum;
               mid_v_d = 1'b1;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         chain_q  <= IV;
         digest_q <= '0;
         dv_q     <= 1'b0;
         blk_q    <= '0;
         nb_q     <= BLK_W'(1);
`ifdef SHA_MIDSTATE_EN
         mid_q    <= '0;
         mid_v_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         chain_q  <= chain_d;
         digest_q <= digest_d;
         dv_q     <= dv_d;
         blk_q    <= blk_d;
         nb_q     <= nb_d;
`ifdef SHA_MIDSTATE_EN
         mid_q    <= mid_d;
         mid_v_q  <= mid_v_d;
`endif
      end
   end

endmodule

// File: tb/tb_sha256_state_acc.sv
// tb_sha256_state_acc: self-checking bench for sha256_state_acc.
// Expected digests are queued when the final block is driven, popped on digest_valid.
module tb_sha256_state_acc;

   localparam int N = 256;
   localparam logic [N-1:0] IV = {
      32'h5be0cd19, 32'h1f83d9ab,
      32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372,
      32'hbb67ae85, 32'h6a09e667
   };
   localparam logic [N-1:0] ABC = {
      32'hf20015ad, 32'hb410ff61,
      32'h96177a9c, 32'hb00361a3,
      32'h5dae2223, 32'h414140de,
      32'h8f01cfea, 32'hba7816bf
   };

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
`ifdef SHA_MIDSTATE_EN
   logic         start_mid;
`endif
   logic [3:0]   num_blocks;
   logic         comp_valid;
   logic         comp_ready;
   logic [N-1:0] comp_in;
   logic [N-1:0] chain_out;
   logic [N-1:0] digest;
   logic         digest_valid;
   logic         busy;
   logic [3:0]   blk_idx;

   int checks = 0;
   int errors = 0;
   logic [N-1:0] sb[$];

   sha256_state_acc dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
`ifdef SHA_MIDSTATE_EN
      .start_mid    (start_mid),
`endif
      .num_blocks   (num_blocks),
      .comp_valid   (comp_valid),
      .comp_ready   (comp_ready),
      .comp_in      (comp_in),
      .chain_out    (chain_out),
      .digest       (digest),
      .digest_valid (digest_valid),
      .busy         (busy),
      .blk_idx      (blk_idx)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      logic [N-1:0] exp;
      if (digest_valid === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL pulse_unexpected digest=%h required=no pulse",
                     digest);
         end else begin
            exp = sb.pop_front();
            if (digest !== exp) begin
               errors++;
               $display("FAIL digest got=%h required=%h", digest, exp);
            end
         end
      end
   end

   function automatic logic [N-1:0] addw(input logic [N-1:0] a,
                                         input logic [N-1:0] b);
      logic [N-1:0] r;
      for (int i = 0; i < 8; i++)
         r[i*32 +: 32] = a[i*32 +: 32] + b[i*32 +: 32];
      return r;
   endfunction

   function automatic logic [N-1:0] subw(input logic [N-1:0] a,
                                         input logic [N-1:0] b);
      logic [N-1:0] r;
      for (int i = 0; i < 8; i++)
         r[i*32 +: 32] = a[i*32 +: 32] - b[i*32 +: 32];
      return r;
   endfunction

   function automatic logic [N-1:0] rnd();
      logic [N-1:0] r;
      for (int i = 0; i < 8; i++)
         r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [N-1:0] c);
      comp_valid = 1'b1;
      comp_in    = c;
      tick();
      comp_valid = 1'b0;
   endtask

   task automatic begin_msg(input logic [3:0] nb);
      start      = 1'b1;
      num_blocks = nb;
      tick();
      start      = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
`ifdef SHA_MIDSTATE_EN
      start_mid = 1'b0;
`endif
      num_blocks = 4'd1;
      comp_valid = 1'b0;
      comp_in = '0;
      tick();
      tick();
      rst = 1'b0;
      repeat (3) tick();
      checks++;
      if (chain_out !== IV) begin
         errors++;
         $display("FAIL rst_chain got=%h required=%h", chain_out, IV);
      end
      checks++;
      if (digest !== '0) begin
         errors++;
         $display("FAIL rst_digest got=%h required=0", digest);
      end
      checks++;
      if ({digest_valid, busy, comp_ready} !== 3'b000) begin
         errors++;
         $display("FAIL rst_flags got=%b required=000",
                  {digest_valid, busy, comp_ready});
      end
      checks++;
      if (blk_idx !== 4'd0) begin
         errors++;
         $display("FAIL rst_blk got=%0d required=0", blk_idx);
      end
   endtask

   task automatic test_abc();
      begin_msg(4'd1);
      checks++;
      if ({busy, comp_ready} !== 2'b11 || chain_out !== IV) begin
         errors++;
         $display("FAIL abc_accum busy/ready=%b chain=%h required=11 IV",
                  {busy, comp_ready}, chain_out);
      end
      sb.push_back(ABC);
      send(subw(ABC, IV));
      checks++;
      if (digest !== ABC) begin
         errors++;
         $display("FAIL abc_digest got=%h required=%h", digest, ABC);
      end
      checks++;
      if (chain_out !== IV || busy !== 1'b0) begin
         errors++;
         $display("FAIL abc_done chain=%h busy=%b required=IV 0",
                  chain_out, busy);
      end
      tick();
      checks++;
      if (digest_valid !== 1'b0 || digest !== ABC) begin
         errors++;
         $display("FAIL abc_hold dv=%b digest=%h required=0 %h",
                  digest_valid, digest, ABC);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL abc_pulse pending=%0d required=0", sb.size());
      end
   endtask

   task automatic test_wrap();
      logic [N-1:0] c;
      logic [N-1:0] exp;
      c = '0;
      c[255:224] = 32'ha41f32e7;
      exp = IV;
      exp[255:224] = 32'h0;
      begin_msg(4'd1);
      sb.push_back(exp);
      send(c);
      checks++;
      if (digest !== exp) begin
         errors++;
         $display("FAIL wrap_digest got=%h required=%h", digest, exp);
      end
      tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL wrap_pulse pending=%0d required=0", sb.size());
      end
   endtask

   task automatic test_gapped();
      logic [N-1:0] c0;
      logic [N-1:0] c1;
      c0 = rnd();
      c1 = rnd();
      begin_msg(4'd2);
      send(c0);
      checks++;
      if (chain_out !== addw(IV, c0) || blk_idx !== 4'd1) begin
         errors++;
         $display("FAIL gap_blk0 chain=%h blk=%0d required=%h 1",
                  chain_out, blk_idx, addw(IV, c0));
      end
      repeat (3) tick();
      checks++;
      if (comp_ready !== 1'b1 || chain_out !== addw(IV, c0)) begin
         errors++;
         $display("FAIL gap_idle ready=%b chain=%h required=1 %h",
                  comp_ready, chain_out, addw(IV, c0));
      end
      sb.push_back(addw(addw(IV, c0), c1));
      send(c1);
      tick();
      checks++;
      if (sb.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL gap_done pending=%0d busy=%b required=0 0",
                  sb.size(), busy);
      end
   endtask

   task automatic test_interrupt();
      logic [N-1:0] c0;
      logic [N-1:0] c1;
      c0 = rnd();
      c1 = rnd();
      begin_msg(4'd2);
      send(c0);
      start = 1'b1;
      num_blocks = 4'd2;
      comp_valid = 1'b1;
      comp_in = c1;
      tick();
      start = 1'b0;
      comp_valid = 1'b0;
      checks++;
      if (blk_idx !== 4'd0 || chain_out !== IV || busy !== 1'b1) begin
         errors++;
         $display("FAIL int_start blk=%0d chain=%h busy=%b required=0 IV 1",
                  blk_idx, chain_out, busy);
      end
      send(c1);
      checks++;
      if (chain_out !== addw(IV, c1) || blk_idx !== 4'd1) begin
         errors++;
         $display("FAIL int_resume chain=%h blk=%0d required=%h 1",
                  chain_out, blk_idx, addw(IV, c1));
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (chain_out !== IV || digest !== '0 || blk_idx !== 4'd0 ||
          {digest_valid, busy, comp_ready} !== 3'b000) begin
         errors++;
         $display("FAIL int_rst chain=%h digest=%h blk=%0d flags=%b required=IV 0 0 000",
                  chain_out, digest, blk_idx,
                  {digest_valid, busy, comp_ready});
      end
      send(c0);
      tick();
      checks++;
      if (chain_out !== IV || blk_idx !== 4'd0) begin
         errors++;
         $display("FAIL int_idle_ignore chain=%h blk=%0d required=IV 0",
                  chain_out, blk_idx);
      end
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] c0;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] c;
      c0 = rnd();
      a = rnd();
      b = rnd();
      c = rnd();
      begin_msg(4'd0);
      sb.push_back(addw(IV, c0));
      send(c0);
      begin_msg(4'd3);
      checks++;
      if (busy !== 1'b1 || blk_idx !== 4'd0 || chain_out !== IV) begin
         errors++;
         $display("FAIL b2b_restart busy=%b blk=%0d chain=%h required=1 0 IV",
                  busy, blk_idx, chain_out);
      end
      comp_valid = 1'b1;
      comp_in = a;
      tick();
      comp_in = b;
      tick();
      checks++;
      if (blk_idx !== 4'd2 || chain_out !== addw(addw(IV, a), b)) begin
         errors++;
         $display("FAIL b2b_mid blk=%0d chain=%h required=2 %h",
                  blk_idx, chain_out, addw(addw(IV, a), b));
      end
      sb.push_back(addw(addw(addw(IV, a), b), c));
      comp_in = c;
      tick();
      comp_valid = 1'b0;
      tick();
      checks++;
      if (sb.size() != 0 || busy !== 1'b0 || blk_idx !== 4'd0) begin
         errors++;
         $display("FAIL b2b_done pending=%0d busy=%b blk=%0d required=0 0 0",
                  sb.size(), busy, blk_idx);
      end
   endtask

`ifdef SHA_MIDSTATE_EN
   task automatic test_midstate();
      logic [N-1:0] c0;
      logic [N-1:0] c1;
      logic [N-1:0] c2;
      c0 = rnd();
      c1 = rnd();
      c2 = rnd();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      start_mid = 1'b1;
      num_blocks = 4'd1;
      tick();
      start_mid = 1'b0;
      checks++;
      if (blk_idx !== 4'd0 || chain_out !== IV || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_cold blk=%0d chain=%h busy=%b required=0 IV 1",
                  blk_idx, chain_out, busy);
      end
      sb.push_back(addw(IV, c2));
      send(c2);
      begin_msg(4'd2);
      send(c0);
      sb.push_back(addw(addw(IV, c0), c1));
      send(c1);
      start_mid = 1'b1;
      num_blocks = 4'd2;
      tick();
      start_mid = 1'b0;
      checks++;
      if (blk_idx !== 4'd1 || chain_out !== addw(IV, c0)) begin
         errors++;
         $display("FAIL mid_resume blk=%0d chain=%h required=1 %h",
                  blk_idx, chain_out, addw(IV, c0));
      end
      sb.push_back(addw(addw(IV, c0), c2));
      send(c2);
      tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL mid_pulse pending=%0d required=0", sb.size());
      end
   endtask
`endif

   initial begin
      test_reset();
      test_abc();
      test_wrap();
      test_gapped();
      test_interrupt();
      test_back_to_back();
`ifdef SHA_MIDSTATE_EN
      test_midstate();
`endif
      repeat (2) tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL final_pending pending=%0d required=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
